// File: rtl/mac_pipe_ctrl.sv
// Flow controller for the shift-add multiply/sum pipeline: per-stage valid tracking,
// bubble-collapsing load enables, drain/flush sequencing. `PIPE_PERF_CNT_EN adds perf counters.
`timescale 1ns/1ps
module mac_pipe_ctrl #(
   parameter int STAGES = 4,
   parameter int OCC_W  = $clog2(STAGES + 1),
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [STAGES-1:0] stage_en,
   output logic [STAGES-1:0] stage_vld,
   input  logic              flush,
   input  logic              drain_req,
   output logic              drain_done,
   output logic              busy,
   output logic [OCC_W-1:0]  occupancy
`ifdef PIPE_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]  acc_cnt,
   output logic [CNT_W-1:0]  stall_cnt
`endif
);

   if (STAGES < 2 || CNT_W < 1) begin : g_bad_cfg
      $error("mac_pipe_ctrl: STAGES must be >= 2 and CNT_W >= 1");
   end

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

   state_e              state_q, state_d;
   logic [STAGES-1:0]   vld_q, vld_d;
   logic                drain_done_q, drain_done_d;
   logic                accept;

   // A stage may load when it is empty or when everything downstream moves,
   // so bubbles are squeezed out before intake stalls.
   always_comb begin
      logic chain;
      chain                = ~vld_q[STAGES-1] | out_ready;
      stage_en             = '0;
      stage_en[STAGES-1]   = chain;
      for (int i = STAGES - 2; i >= 0; i--) begin
         chain       = ~vld_q[i] | chain;
         stage_en[i] = chain;
      end
      if (flush) stage_en = '0;
      in_ready = stage_en[0] & (state_q != DRAIN) & ~flush;
      accept   = in_valid & in_ready;
   end

   always_comb begin
      vld_d = vld_q;
      if (stage_en[0]) vld_d[0] = accept;
      for (int i = 1; i < STAGES; i++) begin
         if (stage_en[i]) vld_d[i] = vld_q[i-1];
      end
      if (flush) vld_d = '0;
   end

   // Next-state: flush wins over everything and retires any pending drain as empty.
   always_comb begin
      state_d      = state_q;
      drain_done_d = 1'b0;
      if (flush) begin
         state_d      = IDLE;
         drain_done_d = (state_q == DRAIN) | drain_req;
      end else begin
         case (state_q)
            IDLE: begin
               if (drain_req)   state_d = DRAIN;
               else if (accept) state_d = RUN;
            end
            RUN: begin
               if (drain_req)          state_d = DRAIN;
               else if (vld_d == '0)   state_d = IDLE;
            end
            DRAIN: begin
               if (vld_d == '0) begin
                  state_d      = IDLE;
                  drain_done_d = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         vld_q        <= '0;
         drain_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         vld_q        <= vld_d;
         drain_done_q <= drain_done_d;
      end
   end

   always_comb begin
      out_valid  = vld_q[STAGES-1];
      stage_vld  = vld_q;
      drain_done = drain_done_q;
      busy       = (|vld_q) | (state_q != IDLE);
      occupancy  = '0;
      for (int i = 0; i < STAGES; i++) begin
         occupancy = occupancy + OCC_W'(vld_q[i]);
      end
   end

`ifdef PIPE_PERF_CNT_EN
   logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   // Both counters stick at all-ones rather than wrapping.
   always_comb begin
      acc_cnt_d   = acc_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (flush) begin
         acc_cnt_d   = '0;
         stall_cnt_d = '0;
      end else begin
         if (accept && acc_cnt_q != '1) acc_cnt_d = acc_cnt_q + 1'b1;
         if (out_valid && !out_ready && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_cnt_q   <= '0;
         stall_cnt_q <= '0;
      end else begin
         acc_cnt_q   <= acc_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign acc_cnt   = acc_cnt_q;
   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mac_pipe_ctrl.sv
// Directed, table-driven bench for mac_pipe_ctrl (STAGES=4), plus latency and
// backpressure sequences; counter checks only when PIPE_PERF_CNT_EN is defined.
`timescale 1ns/1ps
module tb_mac_pipe_ctrl;

   localparam int STAGES = 4;
   localparam int OCC_W  = 3;
   localparam int CNT_W  = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid, in_ready, out_valid, out_ready;
   logic [STAGES-1:0] stage_en, stage_vld;
   logic              flush, drain_req, drain_done, busy;
   logic [OCC_W-1:0]  occupancy;
`ifdef PIPE_PERF_CNT_EN
   logic [CNT_W-1:0]  acc_cnt, stall_cnt;
`endif

   always #5 clk = ~clk;

   mac_pipe_ctrl #(.STAGES(STAGES), .OCC_W(OCC_W), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .stage_en   (stage_en),
      .stage_vld  (stage_vld),
      .flush      (flush),
      .drain_req  (drain_req),
      .drain_done (drain_done),
      .busy       (busy),
      .occupancy  (occupancy)
`ifdef PIPE_PERF_CNT_EN
      ,
      .acc_cnt    (acc_cnt),
      .stall_cnt  (stall_cnt)
`endif
   );

   typedef struct {
      logic       rst, iv, ordy, fl, dr;
      logic       ir;
      logic [3:0] en;
      logic [3:0] sv;
      logic [2:0] occ;
      logic       busy, dd;
   } vec_t;

   vec_t tbl[$];
   int   n_vec = 0;
   int   n_err = 0;

   function automatic vec_t mk(input logic r, iv, ordy, fl, dr, ir, input logic [3:0] en, sv,
                               input int occ, input logic b, dd);
      vec_t v;
      v.rst = r;  v.iv = iv; v.ordy = ordy; v.fl = fl; v.dr = dr;
      v.ir  = ir; v.en = en; v.sv = sv; v.occ = 3'(occ); v.busy = b; v.dd = dd;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, n_acc, n_out, n_irlow;

      // Row fields: rst iv ordy fl dr | ir en sv occ busy dd
      // Stream: 10 beats back to back, results from cycle 4, contiguous.
      for (int k = 0; k < 4; k++)
         tbl.push_back(mk(0,1,1,0,0, 1,4'hF, 4'((1 << k) - 1), k, k != 0, 0));
      for (int k = 0; k < 6; k++) tbl.push_back(mk(0,1,1,0,0, 1,4'hF,4'b1111,4,1,0));
      tbl.push_back(mk(0,0,1,0,0, 1,4'hF,4'b1111,4,1,0));
      tbl.push_back(mk(0,0,1,0,0, 1,4'hF,4'b1110,3,1,0));
      tbl.push_back(mk(0,0,1,0,0, 1,4'hF,4'b1100,2,1,0));
      tbl.push_back(mk(0,0,1,0,0, 1,4'hF,4'b1000,1,1,0));
      tbl.push_back(mk(0,0,1,0,0, 1,4'hF,4'b0000,0,0,0));
      // Backpressure: full pipe, out_ready low for 3 cycles.
      for (int k = 0; k < 4; k++)
         tbl.push_back(mk(0,1,1,0,0, 1,4'hF, 4'((1 << k) - 1), k, k != 0, 0));
      for (int k = 0; k < 3; k++) tbl.push_back(mk(0,1,0,0,0, 0,4'h0,4'b1111,4,1,0));
      tbl.push_back(mk(0,0,1,0,0, 1,4'hF,4'b1111,4,1,0));
      tbl.push_back(mk(0,0,1,0,0, 1,4'hF,4'b1110,3,1,0));
      tbl.push_back(mk(0,0,1,0,0, 1,4'hF,4'b1100,2,1,0));
      tbl.push_back(mk(0,0,1,0,0, 1,4'hF,4'b1000,1,1,0));
      tbl.push_back(mk(0,0,1,0,0, 1,4'hF,4'b0000,0,0,0));
      // Bubble collapse: beats at 0 and 2, consumer stalls from 3.
      tbl.push_back(mk(0,1,1,0,0, 1,4'hF,4'b0000,0,0,0));
      tbl.push_back(mk(0,0,1,0,0, 1,4'hF,4'b0001,1,1,0));
      tbl.push_back(mk(0,1,1,0,0, 1,4'hF,4'b0010,1,1,0));
      tbl.push_back(mk(0,0,0,0,0, 1,4'hF,4'b0101,2,1,0));
      tbl.push_back(mk(0,1,0,0,0, 1,4'b0111,4'b1010,2,1,0));
      tbl.push_back(mk(0,1,0,0,0, 1,4'b0011,4'b1101,3,1,0));
      tbl.push_back(mk(0,1,0,0,0, 0,4'b0000,4'b1111,4,1,0));
      tbl.push_back(mk(0,0,1,0,0, 1,4'hF,4'b1111,4,1,0));
      tbl.push_back(mk(0,0,1,0,0, 1,4'hF,4'b1110,3,1,0));
      tbl.push_back(mk(0,0,1,0,0, 1,4'hF,4'b1100,2,1,0));
      tbl.push_back(mk(0,0,1,0,0, 1,4'hF,4'b1000,1,1,0));
      tbl.push_back(mk(0,0,1,0,0, 1,4'hF,4'b0000,0,0,0));
      // Drain with 3 beats in flight.
      for (int k = 0; k < 3; k++)
         tbl.push_back(mk(0,1,1,0,0, 1,4'hF, 4'((1 << k) - 1), k, k != 0, 0));
      tbl.push_back(mk(0,0,1,0,1, 1,4'hF,4'b0111,3,1,0));
      tbl.push_back(mk(0,1,1,0,0, 0,4'hF,4'b1110,3,1,0));
      tbl.push_back(mk(0,1,1,0,0, 0,4'hF,4'b1100,2,1,0));
      tbl.push_back(mk(0,1,1,0,0, 0,4'hF,4'b1000,1,1,0));
      tbl.push_back(mk(0,0,1,0,0, 1,4'hF,4'b0000,0,0,1));
      tbl.push_back(mk(0,0,1,0,0, 1,4'hF,4'b0000,0,0,0));
      // Drain request on an idle, empty pipe.
      tbl.push_back(mk(0,0,1,0,1, 1,4'hF,4'b0000,0,0,0));
      tbl.push_back(mk(0,0,1,0,0, 0,4'hF,4'b0000,0,1,0));
      tbl.push_back(mk(0,0,1,0,0, 1,4'hF,4'b0000,0,0,1));
      tbl.push_back(mk(0,0,1,0,0, 1,4'hF,4'b0000,0,0,0));
      // Flush a full pipe with in_valid high.
      for (int k = 0; k < 4; k++)
         tbl.push_back(mk(0,1,1,0,0, 1,4'hF, 4'((1 << k) - 1), k, k != 0, 0));
      tbl.push_back(mk(0,1,1,1,0, 0,4'h0,4'b1111,4,1,0));
      tbl.push_back(mk(0,0,1,0,0, 1,4'hF,4'b0000,0,0,0));
      // Flush while draining: drain retires as empty.
      tbl.push_back(mk(0,1,0,0,0, 1,4'hF,4'b0000,0,0,0));
      tbl.push_back(mk(0,0,0,0,1, 1,4'hF,4'b0001,1,1,0));
      tbl.push_back(mk(0,0,0,1,0, 0,4'h0,4'b0010,1,1,0));
      tbl.push_back(mk(0,0,1,0,0, 1,4'hF,4'b0000,0,0,1));
      tbl.push_back(mk(0,0,1,0,0, 1,4'hF,4'b0000,0,0,0));
      // Flush and drain_req in the same cycle.
      tbl.push_back(mk(0,1,1,0,0, 1,4'hF,4'b0000,0,0,0));
      tbl.push_back(mk(0,1,1,1,1, 0,4'h0,4'b0001,1,1,0));
      tbl.push_back(mk(0,0,1,0,0, 1,4'hF,4'b0000,0,0,1));
      tbl.push_back(mk(0,0,1,0,0, 1,4'hF,4'b0000,0,0,0));
      // Reset with 2 beats in flight: nothing emerges afterwards.
      tbl.push_back(mk(0,1,1,0,0, 1,4'hF,4'b0000,0,0,0));
      tbl.push_back(mk(0,1,1,0,0, 1,4'hF,4'b0001,1,1,0));
      tbl.push_back(mk(1,1,1,0,0, 1,4'hF,4'b0011,2,1,0));
      for (int k = 0; k < 3; k++) tbl.push_back(mk(0,0,1,0,0, 1,4'hF,4'b0000,0,0,0));

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0; drain_req = 1'b0;
      repeat (2) @(posedge clk);

      foreach (tbl[i]) begin
         step();
         rst = tbl[i].rst; in_valid = tbl[i].iv; out_ready = tbl[i].ordy;
         flush = tbl[i].fl; drain_req = tbl[i].dr;
         @(negedge clk);
         check($sformatf("vec%0d{ir,en,sv,ov,occ,busy,dd}", i),
               32'({in_ready, stage_en, stage_vld, out_valid, occupancy, busy, drain_done}),
               32'({tbl[i].ir, tbl[i].en, tbl[i].sv, tbl[i].sv[3], tbl[i].occ,
                    tbl[i].busy, tbl[i].dd}));
      end

      // Latency of a single beat from accept to out_valid.
      step();
      rst = 1'b0; in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0; drain_req = 1'b0;
      @(negedge clk);
      check("lat_accept", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      lat = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (out_valid) begin
            lat = k;
            break;
         end
      end
      check("latency", 32'(lat), 32'(STAGES));
      repeat (3) step();

      // Backpressure with continuous offer: count stalls and beats in/out.
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_acc = 0; n_out = 0; n_irlow = 0;
      for (int c = 0; c < 11; c++) begin
         in_valid  = 1'b1;
         out_ready = !(c >= 4 && c <= 6);
         @(negedge clk);
         if (in_valid && in_ready) n_acc++;
         if (!in_ready) n_irlow++;
         if (out_valid && out_ready) n_out++;
         step();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (out_valid && out_ready) n_out++;
         if (!busy) break;
         step();
      end
      check("bp_in_ready_low", 32'(n_irlow), 32'd3);
      check("bp_accepted", 32'(n_acc), 32'd8);
      check("bp_emitted", 32'(n_out), 32'd8);
      check("bp_idle_after", 32'(busy), 32'd0);
`ifdef PIPE_PERF_CNT_EN
      check("stall_cnt", 32'(stall_cnt), 32'd3);
      check("acc_cnt", 32'(acc_cnt), 32'd8);
      step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      @(negedge clk);
      check("acc_cnt_flush", 32'(acc_cnt), 32'd0);
      check("stall_cnt_flush", 32'(stall_cnt), 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
